majority_sample_collector: RTL and testbench
============================================

Name: majority_sample_collector

Overview:
- Upstream feeder for majority_circuit. Accepts one serial sample bit per valid/ready handshake and assembles N bits into a parallel vector.
- Counts ones on the fly. Presents the completed vector plus ones-count on a valid/ready output that drives majority_circuit.in.
- Holds each completed word until it is consumed, then starts a fresh window.

Parameters:
- N, 7, window length in samples; must be odd and >= 3.
- CW, $clog2(N+1), width of the ones-count and the fill counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous abort; discards the partial or held window.
- s_valid  input  1  serial sample valid.
- s_ready  output  1  collector can accept a sample.
- s_bit  input  1  serial sample value.
- m_valid  output  1  completed window available.
- m_ready  input  1  downstream consumes window.
- m_vec  output  N  assembled window; connects to majority_circuit.in.
- m_ones  output  CW  number of 1s in m_vec.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state is updated on the rising clk edge only.
- Reset values: state=FILL, fill count=0, m_vec=0, m_ones=0, m_valid=0, s_ready=1.
- FSM states:
  - FILL: s_ready=1, m_valid=0. On s_valid&&s_ready:
    - vec <= {vec[N-2:0], s_bit};
    - ones <= ones + s_bit;
    - fill <= fill + 1.
    - When the accepted sample is the Nth (fill==N-1), go to HOLD on the same edge.
  - HOLD: s_ready=0, m_valid=1. m_vec and m_ones stay stable. On m_valid&&m_ready, clear vec, ones and fill, then go to FILL.
- Bit order: the first accepted sample lands in m_vec[N-1]; the last lands in m_vec[0].
- Latency: m_valid rises on the cycle after the Nth accepted sample.
- Throughput: N+1 cycles per window minimum. In HOLD, s_ready=0 on the handshake cycle; the first sample of the next window is accepted the cycle after.
- m_ones never exceeds N; no wrap. fill never exceeds N-1.
- In FILL with s_valid=0, no state changes.
- m_ready asserted in FILL is ignored.
- Backpressure: m_ready low in HOLD holds all outputs indefinitely.
- clr: behaves like rst for the datapath and FSM: state=FILL, fill=0, vec=0, ones=0, next cycle.
  - clr beats a simultaneous sample acceptance and a simultaneous m_handshake. A window being consumed while clr is high counts as dropped.
- rst has priority over clr.
- Reset or clr mid-fill discards the partial window; no m_valid results.
- Outputs are registered; there is no combinational path from s_* to m_*.

Optional Feature:
- Macro MAJ_LOCAL_DECISION_EN.
- Defined: adds output port m_maj (1 bit) = (m_ones > N/2). It is registered, updates with m_vec, and resets to 0. It serves as a cross-check against majority_circuit.out.
- Not defined: port m_maj is absent and no comparator logic is built. All other behaviour is identical.

Decomposition:
- Shared package majority_pkg:
  - constant MAJ_N = 7;
  - constant MAJ_CW = $clog2(MAJ_N+1);
  - state enum {ST_FILL, ST_HOLD}.
- Majority_circuit and its bench also import MAJ_N from this package.
- Sub-module maj_shift_count (shift register plus ones accumulator plus fill counter) is natural. The top keeps the FSM and handshake.

Test Plan:
- Basic fill: rst for 2 cycles, then s_bit = 1,0,0,1,1,0,1 with s_valid=1 and m_ready=1 -> m_vec=7'b1001101, m_ones=4, m_maj=1, m_valid high for exactly 1 cycle.
- Gaps and backpressure: same bits with s_valid toggled every other cycle, m_ready=0 for 5 cycles after m_valid -> outputs stable at 7'b1001101/4 throughout. s_ready=0 throughout HOLD. Handshake on the first cycle m_ready=1.
- Back-to-back windows: 1111101 then 0001000 -> m_ones=6 then 1, m_maj=1 then 0. The second window's first sample is accepted no earlier than 1 cycle after the first handshake.
- Abort mid-fill: 4 samples, pulse clr, then 7 samples 0000001 -> a single window 7'b0000001, m_ones=1. The earlier partial window never appears.
- Clr versus handshake: in HOLD, assert clr and m_ready together -> next cycle m_valid=0, state FILL, m_ones=0.
- Reset mid-HOLD: in HOLD, assert rst -> next cycle all outputs at reset values, s_ready=1.

Source files
------------

// File: rtl/majority_pkg.sv
// Shared constants and state encoding for the majority sample collector and majority_circuit.
package majority_pkg;

    localparam int MAJ_N  = 7;
    localparam int MAJ_CW = $clog2(MAJ_N + 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } maj_state_e;

endpackage

// File: rtl/maj_shift_count.sv
// Window datapath: shift register, running ones count and fill counter.
// With MAJ_LOCAL_DECISION_EN defined, also registers the local majority decision.
module maj_shift_count
    import majority_pkg::*;
#(
    parameter int N  = MAJ_N,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          shift_en,
    input  logic          s_bit,
    output logic [N-1:0]  vec_o,
    output logic [CW-1:0] ones_o,
    output logic          last_o
`ifdef MAJ_LOCAL_DECISION_EN
    ,
    output logic          maj_o
`endif
);

    logic [N-1:0]  vec_q,  vec_d;
    logic [CW-1:0] ones_q, ones_d;
    logic [CW-1:0] fill_q, fill_d;

    always_comb begin
        vec_d  = vec_q;
        ones_d = ones_q;
        fill_d = fill_q;
        if (clear) begin
            vec_d  = '0;
            ones_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            vec_d  = {vec_q[N-2:0], s_bit};
            ones_d = ones_q + CW'(s_bit);
            // Fill wraps to 0 on the Nth sample; the held window no longer needs it.
            fill_d = last_o ? '0 : fill_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q  <= '0;
            ones_q <= '0;
            fill_q <= '0;
        end else begin
            vec_q  <= vec_d;
            ones_q <= ones_d;
            fill_q <= fill_d;
        end
    end

    assign vec_o  = vec_q;
    assign ones_o = ones_q;
    assign last_o = (fill_q == CW'(N - 1));

`ifdef MAJ_LOCAL_DECISION_EN
    logic maj_q, maj_d;

    always_comb begin
        maj_d = (ones_d > CW'(N / 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            maj_q <= 1'b0;
        end else begin
            maj_q <= maj_d;
        end
    end

    assign maj_o = maj_q;
`endif

endmodule

// File: rtl/majority_sample_collector.sv
// Serial-to-parallel window collector feeding majority_circuit; FSM and handshakes live here.
// Optional m_maj output is built when MAJ_LOCAL_DECISION_EN is defined.
module majority_sample_collector
    import majority_pkg::*;
#(
    parameter  int N  = MAJ_N,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_bit,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [N-1:0]  m_vec,
    output logic [CW-1:0] m_ones
`ifdef MAJ_LOCAL_DECISION_EN
    ,
    output logic          m_maj
`endif
);

    maj_state_e state_q, state_d;
    logic       accept;
    logic       clear;
    logic       last;

    always_comb begin
        s_ready = (state_q == ST_FILL);
        m_valid = (state_q == ST_HOLD);
        // clr wins over both a sample acceptance and a downstream handshake.
        accept  = s_valid && s_ready && !clr;
        clear   = clr || (m_valid && m_ready);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (accept && last) state_d = ST_HOLD;
            ST_HOLD: if (m_ready)        state_d = ST_FILL;
            default:                     state_d = ST_FILL;
        endcase
        if (clr) state_d = ST_FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    maj_shift_count #(
        .N  (N),
        .CW (CW)
    ) u_shift_count (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (accept),
        .s_bit    (s_bit),
        .vec_o    (m_vec),
        .ones_o   (m_ones),
        .last_o   (last)
`ifdef MAJ_LOCAL_DECISION_EN
        ,
        .maj_o    (m_maj)
`endif
    );

endmodule

// File: tb/tb_majority_sample_collector.sv
// Scoreboard bench for majority_sample_collector: directed scenarios then random traffic.
module tb_majority_sample_collector;
    import majority_pkg::*;

    localparam int N  = MAJ_N;
    localparam int CW = MAJ_CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_bit = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [N-1:0]  m_vec;
    logic [CW-1:0] m_ones;
`ifdef MAJ_LOCAL_DECISION_EN
    logic          m_maj;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        int vec;
        int ones;
        int maj;
    } exp_t;

    exp_t exp_q[$];
    int   win_bits[$];
    bit   holding = 1'b0;

    always #5 clk = ~clk;

    majority_sample_collector #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_bit   (s_bit),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_vec   (m_vec),
        .m_ones  (m_ones)
`ifdef MAJ_LOCAL_DECISION_EN
        ,
        .m_maj   (m_maj)
`endif
    );

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at t=%0t", name, act, expv, $time);
        end
    endtask

    // Monitor + reference model. Checks the current cycle, then applies what the coming edge does.
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_ready", int'(s_ready), int'(!holding));
            chk("m_valid", int'(m_valid), int'(holding));
            if (holding && exp_q.size() > 0) begin
                chk("m_vec",  int'(m_vec),  exp_q[0].vec);
                chk("m_ones", int'(m_ones), exp_q[0].ones);
`ifdef MAJ_LOCAL_DECISION_EN
                chk("m_maj",  int'(m_maj),  exp_q[0].maj);
`endif
                if (m_ready && !clr) begin
                    $display("window consumed vec=%b ones=%0d", m_vec, m_ones);
                    void'(exp_q.pop_front());
                end
            end
        end
        if (rst) begin
            win_bits.delete();
            exp_q.delete();
            holding = 1'b0;
        end else if (clr) begin
            win_bits.delete();
            if (holding && exp_q.size() > 0) void'(exp_q.pop_front());
            holding = 1'b0;
        end else if (holding) begin
            if (m_ready) holding = 1'b0;
        end else if (s_valid) begin
            win_bits.push_back(int'(s_bit));
            if (win_bits.size() == N) begin
                exp_t e;
                e.vec  = 0;
                e.ones = 0;
                // First accepted sample is the most significant bit of the window.
                foreach (win_bits[i]) begin
                    e.vec  = e.vec * 2 + win_bits[i];
                    e.ones = e.ones + win_bits[i];
                end
                e.maj = (e.ones > N / 2) ? 1 : 0;
                exp_q.push_back(e);
                win_bits.delete();
                holding = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bit(input logic b);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_bit   = b;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic push_word(input logic [N-1:0] w, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            push_bit(w[N-1-i]);
            if (gaps) tick();
        end
    endtask

    initial begin
        logic [N-1:0] w;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_m_vec",  int'(m_vec),  0);
        chk("rst_m_ones", int'(m_ones), 0);

        // Basic fill with downstream always ready.
        m_ready = 1'b1;
        w = 7'b1001101;
        push_word(w, N, 1'b0);
        repeat (3) tick();

        // Gaps on input, then 5 cycles of backpressure.
        m_ready = 1'b0;
        push_word(w, N, 1'b1);
        repeat (5) tick();
        m_ready = 1'b1;
        repeat (3) tick();

        // Back-to-back windows.
        w = 7'b1111101;
        push_word(w, N, 1'b0);
        w = 7'b0001000;
        push_word(w, N, 1'b0);
        repeat (3) tick();

        // Abort mid-fill.
        w = 7'b1011000;
        push_word(w, 4, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        w = 7'b0000001;
        push_word(w, N, 1'b0);
        repeat (3) tick();

        // clr together with handshake in HOLD.
        m_ready = 1'b0;
        w = 7'b1110110;
        push_word(w, N, 1'b0);
        tick();
        clr = 1'b1;
        m_ready = 1'b1;
        tick();
        clr = 1'b0;
        m_ready = 1'b0;
        chk("clr_hs_m_valid", int'(m_valid), 0);
        chk("clr_hs_m_ones",  int'(m_ones),  0);
        tick();

        // Reset while holding.
        w = 7'b0110111;
        push_word(w, N, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hold_m_valid", int'(m_valid), 0);
        chk("rst_hold_s_ready", int'(s_ready), 1);
        chk("rst_hold_m_vec",   int'(m_vec),   0);
        chk("rst_hold_m_ones",  int'(m_ones),  0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_bit   = $urandom_range(0, 1) == 1;
            m_ready = ($urandom_range(0, 2) != 0);
            clr     = ($urandom_range(0, 99) < 2);
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        s_valid = 1'b0;
        clr     = 1'b0;
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
